pipe_stage_skid_reg: RTL and testbench

//  Generic inter-stage pipeline register with a valid/ready handshake and a 1-entry skid buffer.

---
 rtl/pipe_stage_pkg.sv | 25 ++
 rtl/pipe_stage_skid_reg.sv | 90 +++++++++
 tb/tb_pipe_stage_skid_reg.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding and IF/ID payload layout.
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam int unsigned SHAMT_W   = 5;
   localparam int unsigned PC4_W     = 32;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned SHAMT_LSB = 0;
   localparam int unsigned PC4_LSB   = SHAMT_LSB + SHAMT_W;
   localparam int unsigned INSTR_LSB = PC4_LSB + PC4_W;
   localparam int unsigned IF_ID_W   = INSTR_LSB + INSTR_W;

   // IF/ID payload as carried on i_DATA/o_DATA (instr in the top bits).
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC4_W-1:0]   pc4;
      logic [SHAMT_W-1:0] shamt;
   } if_id_t;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer,
// flush, occupancy and saturating stall counter.
module pipe_stage_skid_reg
   import pipe_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = IF_ID_W,
   parameter bit          FLUSH_ZERO  = 1'b1,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic                   i_FLUSH,
   input  logic                   i_VALID,
   output logic                   o_READY,
   input  logic [DATA_WIDTH-1:0]  i_DATA,
   output logic                   o_VALID,
   input  logic                   i_READY,
   output logic [DATA_WIDTH-1:0]  o_DATA,
   output logic [1:0]             o_OCC,
   output logic [STALL_CNT_W-1:0] o_STALL_CNT
);

   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

   state_e                state_q;
   state_e                state_d;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  xfer_in_c;
   logic                  xfer_out_c;

   assign xfer_in_c  = i_VALID & o_READY;
   assign xfer_out_c = o_VALID & i_READY;

   // Next state; flush overrides every handshake outcome.
   always_comb begin
      state_d = state_q;
      if (i_FLUSH) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (xfer_in_c) state_d = ST_BUSY;
            ST_BUSY: begin
               if (xfer_in_c && !xfer_out_c)      state_d = ST_FULL;
               else if (!xfer_in_c && xfer_out_c) state_d = ST_EMPTY;
            end
            ST_FULL:  if (xfer_out_c) state_d = ST_BUSY;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs are re-registered from the next state so o_READY never sees i_READY combinationally.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q     <= ST_EMPTY;
         o_VALID     <= 1'b0;
         o_READY     <= 1'b1;
         o_OCC       <= 2'd0;
         o_DATA      <= '0;
         skid_q      <= '0;
         o_STALL_CNT <= '0;
      end else begin
         state_q <= state_d;
         o_VALID <= (state_d != ST_EMPTY);
         o_READY <= (state_d != ST_FULL);
         o_OCC   <= 2'(state_d);

         if (o_VALID && !i_READY && (o_STALL_CNT != CNT_MAX))
            o_STALL_CNT <= o_STALL_CNT + STALL_CNT_W'(1);

         if (i_FLUSH) begin
            if (FLUSH_ZERO) begin
               o_DATA <= '0;
               skid_q <= '0;
            end
         end else begin
            case (state_q)
               ST_EMPTY: if (xfer_in_c) o_DATA <= i_DATA;
               ST_BUSY: begin
                  if (xfer_in_c && xfer_out_c) o_DATA <= i_DATA;
                  else if (xfer_in_c)          skid_q <= i_DATA;
               end
               ST_FULL:  if (xfer_out_c) o_DATA <= skid_q;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_skid_reg;

   localparam int unsigned DW = 69;
   localparam int unsigned CW = 69;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance (defaults)
   logic          flush = 1'b0, valid = 1'b0, ready = 1'b0;
   logic [DW-1:0] data = '0;
   logic          o_ready, o_valid;
   logic [DW-1:0] o_data;
   logic [1:0]    o_occ;
   logic [15:0]   o_cnt;

   // Data-retaining flush instance
   logic          nz_flush = 1'b0, nz_valid = 1'b0, nz_ready = 1'b0;
   logic [7:0]    nz_data = '0;
   logic          nz_o_ready, nz_o_valid;
   logic [7:0]    nz_o_data;
   logic [1:0]    nz_o_occ;
   logic [15:0]   nz_o_cnt;

   // Narrow stall counter instance
   logic          sat_flush = 1'b0, sat_valid = 1'b0, sat_ready = 1'b0;
   logic [7:0]    sat_data = '0;
   logic          sat_o_ready, sat_o_valid;
   logic [7:0]    sat_o_data;
   logic [1:0]    sat_o_occ;
   logic [2:0]    sat_o_cnt;

   pipe_stage_skid_reg dut (
      .i_CLK(clk), .i_RST(rst), .i_FLUSH(flush), .i_VALID(valid), .o_READY(o_ready),
      .i_DATA(data), .o_VALID(o_valid), .i_READY(ready), .o_DATA(o_data),
      .o_OCC(o_occ), .o_STALL_CNT(o_cnt));

   pipe_stage_skid_reg #(.DATA_WIDTH(8), .FLUSH_ZERO(1'b0), .STALL_CNT_W(16)) dut_nz (
      .i_CLK(clk), .i_RST(rst), .i_FLUSH(nz_flush), .i_VALID(nz_valid), .o_READY(nz_o_ready),
      .i_DATA(nz_data), .o_VALID(nz_o_valid), .i_READY(nz_ready), .o_DATA(nz_o_data),
      .o_OCC(nz_o_occ), .o_STALL_CNT(nz_o_cnt));

   pipe_stage_skid_reg #(.DATA_WIDTH(8), .FLUSH_ZERO(1'b1), .STALL_CNT_W(3)) dut_sat (
      .i_CLK(clk), .i_RST(rst), .i_FLUSH(sat_flush), .i_VALID(sat_valid), .o_READY(sat_o_ready),
      .i_DATA(sat_data), .o_VALID(sat_o_valid), .i_READY(sat_ready), .o_DATA(sat_o_data),
      .o_OCC(sat_o_occ), .o_STALL_CNT(sat_o_cnt));

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Reference model: the stage is a FIFO of depth 2; o_DATA shows the head, or the last shown value when empty.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_disp = '0;
   int unsigned   m_cnt = 0;

   task automatic model_reset();
      mq.delete();
      m_disp = '0;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      bit in_x, out_x;
      in_x  = valid && (mq.size() < 2);
      out_x = (mq.size() > 0) && ready;
      if ((mq.size() > 0) && !ready && (m_cnt < 65535)) m_cnt++;
      if (flush) begin
         mq.delete();
         m_disp = '0;
      end else begin
         if (out_x) void'(mq.pop_front());
         if (in_x)  mq.push_back(data);
         if (mq.size() > 0) m_disp = mq[0];
      end
   endtask

   task automatic check_main(input string tag);
      check({tag, " valid"}, CW'(o_valid), CW'(mq.size() > 0));
      check({tag, " ready"}, CW'(o_ready), CW'(mq.size() < 2));
      check({tag, " occ"},   CW'(o_occ),   CW'(mq.size()));
      check({tag, " data"},  CW'(o_data),  CW'(m_disp));
      check({tag, " stall"}, CW'(o_cnt),   CW'(m_cnt));
   endtask

   // One clock: model advances on the same pre-edge inputs, outputs sampled 1 time unit after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit            fl, v, r;
      logic [DW-1:0] d;
      bit            ev, er;
      logic [1:0]    eo;
      logic [DW-1:0] ed;
      int unsigned   ec;
   } vec_t;

   function automatic vec_t mk(bit fl, bit v, bit r, logic [DW-1:0] d, bit ev, bit er,
                               logic [1:0] eo, logic [DW-1:0] ed, int unsigned ec);
      vec_t t;
      t.fl = fl; t.v = v; t.r = r; t.d = d;
      t.ev = ev; t.er = er; t.eo = eo; t.ed = ed; t.ec = ec;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      // Streaming 1..8 with continuous ready, then drain
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(0, 1, 1, DW'(k), 1, 1, 2'd1, DW'(k), 0));
      tbl.push_back(mk(0, 0, 1, '0, 0, 1, 2'd0, DW'(8), 0));
      // Back-pressure: A, B fill the stage, C waits upstream, then release
      tbl.push_back(mk(0, 1, 0, DW'('hA), 1, 1, 2'd1, DW'('hA), 0));
      tbl.push_back(mk(0, 1, 0, DW'('hB), 1, 0, 2'd2, DW'('hA), 1));
      tbl.push_back(mk(0, 1, 0, DW'('hC), 1, 0, 2'd2, DW'('hA), 2));
      tbl.push_back(mk(0, 1, 0, DW'('hC), 1, 0, 2'd2, DW'('hA), 3));
      tbl.push_back(mk(0, 1, 1, DW'('hC), 1, 1, 2'd1, DW'('hB), 3));
      tbl.push_back(mk(0, 1, 1, DW'('hC), 1, 1, 2'd1, DW'('hC), 3));
      tbl.push_back(mk(0, 0, 1, '0, 0, 1, 2'd0, DW'('hC), 3));
      // Flush while FULL with D offered: zeroed, D dropped
      tbl.push_back(mk(0, 1, 0, DW'('h11), 1, 1, 2'd1, DW'('h11), 3));
      tbl.push_back(mk(0, 1, 0, DW'('h22), 1, 0, 2'd2, DW'('h11), 4));
      tbl.push_back(mk(1, 1, 0, DW'('h33), 0, 1, 2'd0, '0, 5));
      tbl.push_back(mk(0, 0, 1, '0, 0, 1, 2'd0, '0, 5));
      // Flush in EMPTY drops an otherwise accepted input
      tbl.push_back(mk(1, 1, 1, DW'('h44), 0, 1, 2'd0, '0, 5));
      tbl.push_back(mk(0, 0, 1, '0, 0, 1, 2'd0, '0, 5));

      // Reset state
      #12;
      check("reset valid", CW'(o_valid), CW'(0));
      check("reset ready", CW'(o_ready), CW'(1));
      check("reset occ",   CW'(o_occ),   CW'(0));
      check("reset data",  CW'(o_data),  CW'(0));
      check("reset stall", CW'(o_cnt),   CW'(0));
      model_reset();
      #5 rst = 1'b0;

      foreach (tbl[i]) begin
         flush = tbl[i].fl; valid = tbl[i].v; ready = tbl[i].r; data = tbl[i].d;
         cycle();
         check($sformatf("vec%0d valid", i), CW'(o_valid), CW'(tbl[i].ev));
         check($sformatf("vec%0d ready", i), CW'(o_ready), CW'(tbl[i].er));
         check($sformatf("vec%0d occ", i),   CW'(o_occ),   CW'(tbl[i].eo));
         check($sformatf("vec%0d data", i),  CW'(o_data),  CW'(tbl[i].ed));
         check($sformatf("vec%0d stall", i), CW'(o_cnt),   CW'(tbl[i].ec));
      end
      flush = 1'b0;

      // Async reset mid-cycle while FULL, then accept on the first edge after release
      valid = 1'b1; ready = 1'b0; data = DW'('h61);
      cycle();
      data = DW'('h62);
      cycle();
      check("prefull occ", CW'(o_occ), CW'(2));
      #2 rst = 1'b1;
      #1;
      check("midrst valid", CW'(o_valid), CW'(0));
      check("midrst data",  CW'(o_data),  CW'(0));
      check("midrst occ",   CW'(o_occ),   CW'(0));
      check("midrst ready", CW'(o_ready), CW'(1));
      check("midrst stall", CW'(o_cnt),   CW'(0));
      model_reset();
      #1 rst = 1'b0;
      valid = 1'b1; ready = 1'b1; data = DW'('h55);
      cycle();
      check("postrst valid", CW'(o_valid), CW'(1));
      check("postrst data",  CW'(o_data),  CW'('h55));
      valid = 1'b0;
      cycle();
      check_main("postrst drain");

      // Flush without zeroing keeps o_DATA
      nz_valid = 1'b1; nz_data = 8'hAB; nz_ready = 1'b0;
      cycle();
      check("nz load data", CW'(nz_o_data), CW'('hAB));
      nz_valid = 1'b0; nz_flush = 1'b1;
      cycle();
      nz_flush = 1'b0;
      check("nz flush valid", CW'(nz_o_valid), CW'(0));
      check("nz flush occ",   CW'(nz_o_occ),   CW'(0));
      check("nz flush data",  CW'(nz_o_data),  CW'('hAB));
      cycle();
      check("nz hold data",   CW'(nz_o_data),  CW'('hAB));

      // Stall counter saturation at 7, untouched by flush
      sat_valid = 1'b1; sat_data = 8'h5A; sat_ready = 1'b0;
      cycle();
      sat_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         check($sformatf("sat cnt k=%0d", k), CW'(sat_o_cnt), CW'((k > 7) ? 7 : k));
      end
      sat_flush = 1'b1;
      cycle();
      sat_flush = 1'b0;
      check("sat flush cnt",   CW'(sat_o_cnt),   CW'(7));
      check("sat flush valid", CW'(sat_o_valid), CW'(0));
      cycle();
      check("sat after cnt",   CW'(sat_o_cnt),   CW'(7));

      // Randomized traffic; an unaccepted offer is held unchanged until taken
      begin
         bit hold;
         hold = 1'b0;
         for (int c = 0; c < 400; c++) begin
            if (!hold) begin
               valid = ($urandom_range(3) != 0);
               data  = {5'($urandom), $urandom, $urandom};
            end
            ready = ($urandom_range(2) != 0);
            flush = ($urandom_range(24) == 0);
            hold  = valid && (mq.size() >= 2) && !flush;
            cycle();
            check_main($sformatf("rnd%0d", c));
         end
         flush = 1'b0; valid = 1'b0; ready = 1'b1;
         for (int c = 0; c < 3; c++) begin
            cycle();
            check_main($sformatf("drain%0d", c));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
